beep_sequencer: RTL
===================

# beep_sequencer

Parametrised beeper that plays a programmable burst of tone pulses on the active-low buzzer pin. A configurable divider sets the tone pitch, and on/off durations are counted in time-base ticks. Burst length is selected per trigger and can be finite or continuous until stopped. The block sits between the alarm/timekeeping logic and the buzzer pad, and supersedes the single free-running toggle beeper.

## Interface

Parameters:
- TONE_DIV_W, 16, width of the tone divider counter.
- TONE_DIV, 1, clk cycles per tone half-period, legal range 1..2^TONE_DIV_W-1. A value of 1 toggles the pin every clk.
- TICK_W, 8, width of the duration counter.
- ON_TICKS, 100, ticks per tone pulse, legal range 1..2^TICK_W-1.
- OFF_TICKS, 100, ticks of silence between pulses, legal range 1..2^TICK_W-1.
- CNT_W, 4, width of the burst count.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  time-base strobe, one-cycle pulse.
- beep  in  1  start request, sampled as a level.
- burst  in  CNT_W  pulses per request, sampled with an accepted beep; 0 means continuous.
- stop  in  1  abort request.
- beep_enabled  in  1  master enable; 0 forces silence.
- beep_port  out  1  buzzer drive, active-low, idle 1.
- busy  out  1  high in ON or OFF.
- done  out  1  one-cycle pulse on natural burst completion.

## Operation

- Registers:
  - state: IDLE, ON or OFF.
  - remaining (CNT_W bits).
  - cont flag.
  - dur_cnt (TICK_W bits).
  - tone_cnt (TONE_DIV_W bits).
- Per-edge priority, highest first: rst, then !beep_enabled, then stop, then start/retrigger, then normal sequencing.
- rst, or beep_enabled=0, or stop: state=IDLE, beep_port=1, counters cleared, no done.
- IDLE:
  - beep_port=1.
  - Start condition: beep=1 with beep_enabled=1 and stop=0.
  - On start: remaining=burst, cont=(burst==0), dur_cnt=ON_TICKS, tone_cnt=0, go to ON.
- ON:
  - tone_cnt increments each clk.
  - When tone_cnt==TONE_DIV-1: beep_port inverts and tone_cnt=0.
  - Each tick decrements dur_cnt.
  - On a tick with dur_cnt==1, the pulse ends and beep_port=1:
    - If !cont and remaining==1: go to IDLE and pulse done.
    - Otherwise: remaining decrements (frozen when cont), dur_cnt=OFF_TICKS, go to OFF.
- OFF:
  - beep_port=1.
  - Each tick decrements dur_cnt.
  - On a tick with dur_cnt==1: dur_cnt=ON_TICKS, tone_cnt=0, go to ON.
- The final pulse has no trailing OFF period.
- beep while busy: handling depends on BEEP_RETRIGGER_EN (see Configuration).
- busy is registered and equals (state!=IDLE).

## Timing

- Reset values: beep_port=1, busy=0, done=0, state=IDLE.
- Start latency:
  - beep is sampled at edge N.
  - busy=1 from edge N.
  - The first beep_port fall is at edge N+TONE_DIV.
- ON tone period is 2*TONE_DIV clk cycles.
- Ticks are counted only in the state they occur in. A tick on the accepting edge is ignored.
- Pulse length is ON_TICKS ticks and the gap is OFF_TICKS ticks. Each has ±1 tick phase uncertainty relative to entry.
- done and the return of busy to 0 occur on the same edge as the final pulse-ending tick.
- stop or a beep_enabled drop forces beep_port=1 and busy=0 on the next edge, mid-pulse or mid-gap.
- Simultaneous beep and stop: stop wins and the request is dropped.
- Simultaneous beep and the final pulse-ending tick, with the macro undefined:
  - The block ends to IDLE with done.
  - If beep is still high next cycle, a new burst starts then.
- A continuous burst (burst=0) never asserts done.

## Configuration

- BEEP_RETRIGGER_EN defined:
  - beep=1 in ON or OFF restarts the sequence: remaining=burst, cont=(burst==0), dur_cnt=ON_TICKS, tone_cnt=0, beep_port=1, state=ON, next edge.
  - No done is emitted.
  - A held-high beep keeps restarting.
- BEEP_RETRIGGER_EN undefined: beep is ignored while busy=1.

## Test plan

Common setup: TONE_DIV=2, ON_TICKS=3, OFF_TICKS=2, tick every 10 clk.

- Reset: assert rst asynchronously between edges -> beep_port=1, busy=0, done=0 immediately and while held.
- burst=2 -> two ON windows of 3 ticks with a 2-tick gap. beep_port toggles every 2 clk in ON. One done pulse on the final pulse-ending tick, then busy=0.
- burst=0 continuous -> pulses repeat indefinitely with no done. Asserting stop mid-ON -> beep_port=1 and busy=0 next edge, no done.
- beep_enabled=0 mid-OFF -> IDLE next edge. beep pulses while disabled -> no activity.
- Retrigger, beep during the second OFF of burst=3:
  - With BEEP_RETRIGGER_EN: restart to ON with remaining=3, 3 full pulses follow, then done.
  - Without: the request is ignored and the original burst completes.
- Async rst mid-ON with beep_port=0 -> beep_port=1 at once. After release, a new burst=1 plays one 3-tick pulse with done.

Source files
------------

// File: rtl/beep_sequencer.sv
// beep_sequencer: burst tone beeper driving an active-low buzzer pin.
// Optional macro BEEP_RETRIGGER_EN: a beep while busy restarts the burst.
module beep_sequencer #(
  parameter int TONE_DIV_W = 16,
  parameter int TONE_DIV   = 1,
  parameter int TICK_W     = 8,
  parameter int ON_TICKS   = 100,
  parameter int OFF_TICKS  = 100,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             beep,
  input  logic [CNT_W-1:0] burst,
  input  logic             stop,
  input  logic             beep_enabled,
  output logic             beep_port,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

  localparam logic [TICK_W-1:0] ON_LD  = TICK_W'(ON_TICKS);
  localparam logic [TICK_W-1:0] OFF_LD = TICK_W'(OFF_TICKS);
  localparam logic [TICK_W-1:0] DUR_1  = TICK_W'(1);
  localparam logic [CNT_W-1:0]  REM_1  = CNT_W'(1);
  localparam logic [TONE_DIV_W-1:0] TONE_TOP =
    TONE_DIV_W'(TONE_DIV - 1);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        remaining, remaining_n;
  logic                    cont, cont_n;
  logic [TICK_W-1:0]       dur_cnt, dur_n;
  logic [TONE_DIV_W-1:0]   tone_cnt, tone_n;
  logic                    port_n;
  logic                    done_n;
  logic                    start;

  // Accept a request from IDLE, or from anywhere when retrigger is built in
`ifdef BEEP_RETRIGGER_EN
  assign start = beep;
`else
  assign start = beep && (state == IDLE);
`endif

  // State, counters and all outputs are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      cont      <= 1'b0;
      dur_cnt   <= '0;
      tone_cnt  <= '0;
      beep_port <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      cont      <= cont_n;
      dur_cnt   <= dur_n;
      tone_cnt  <= tone_n;
      beep_port <= port_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
    end
  end

  // Next-state: disable, stop, start/retrigger, then normal sequencing
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    cont_n      = cont;
    dur_n       = dur_cnt;
    tone_n      = tone_cnt;
    port_n      = beep_port;
    done_n      = 1'b0;
    if (!beep_enabled || stop) begin
      state_n     = IDLE;
      remaining_n = '0;
      cont_n      = 1'b0;
      dur_n       = '0;
      tone_n      = '0;
      port_n      = 1'b1;
    end else if (start) begin
      state_n     = ON;
      remaining_n = burst;
      cont_n      = (burst == '0);
      dur_n       = ON_LD;
      tone_n      = '0;
      port_n      = 1'b1;
    end else begin
      unique case (state)
        ON: begin
          if (tone_cnt == TONE_TOP) begin
            port_n = ~beep_port;
            tone_n = '0;
          end else begin
            tone_n = tone_cnt + 1'b1;
          end
          if (tick) begin
            if (dur_cnt == DUR_1) begin
              port_n = 1'b1;
              tone_n = '0;
              if (!cont && remaining == REM_1) begin
                state_n     = IDLE;
                remaining_n = '0;
                dur_n       = '0;
                done_n      = 1'b1;
              end else begin
                state_n     = OFF;
                remaining_n = cont ? remaining
                                   : remaining - REM_1;
                dur_n       = OFF_LD;
              end
            end else begin
              dur_n = dur_cnt - DUR_1;
            end
          end
        end
        OFF: begin
          port_n = 1'b1;
          if (tick) begin
            if (dur_cnt == DUR_1) begin
              state_n = ON;
              dur_n   = ON_LD;
              tone_n  = '0;
            end else begin
              dur_n = dur_cnt - DUR_1;
            end
          end
        end
        default: begin
          port_n = 1'b1;
        end
      endcase
    end
  end

endmodule
